// File: rtl/pio_ext_if.sv
// Avalon-MM slave bus for pio_ext: 3-bit word address, read/write strobes, 32-bit data.
// Single-cycle accept, readdata registered one cycle after avs_read; no waitrequest.
interface pio_ext_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_ext.sv
// Parallel I/O with per-bit direction, set/clear, debounced inputs and edge-capture irq.
// Reads return one cycle after avs_read; writes land on the write edge; never stalls the bus.
module pio_ext #(
  parameter int unsigned      WIDTH           = 32,
  parameter int unsigned      DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  pio_ext_if.slave         avs,
  input  logic [WIDTH-1:0] pio_in_port,
  output logic [WIDTH-1:0] pio_out_port,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);
  localparam int unsigned   CW      = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

  localparam logic [2:0] A_DATA_IN   = 3'd0;
  localparam logic [2:0] A_DATA_OUT  = 3'd1;
  localparam logic [2:0] A_DIR       = 3'd2;
  localparam logic [2:0] A_IRQ_MASK  = 3'd3;
  localparam logic [2:0] A_EDGE_CAP  = 3'd4;
  localparam logic [2:0] A_OUT_SET   = 3'd5;
  localparam logic [2:0] A_OUT_CLR   = 3'd6;
  localparam logic [2:0] A_EDGE_MODE = 3'd7;

  logic [WIDTH-1:0]         sync1_q, sync_q, sync_prev_q;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]               warm_q, warm_d;
  logic [WIDTH-1:0]         out_q, out_d, dir_q, dir_d;
  logic [WIDTH-1:0]         mask_q, mask_d, mode_q, mode_d;
  logic [WIDTH-1:0]         cap_q, cap_d;
  logic                     irq_q, irq_d;
  logic [31:0]              rdata_q, rdata_d;

  logic                     warm_done;
  logic [WIDTH-1:0]         wd, rise, fall, edges;

  assign warm_done = (warm_q == 2'd3);
  assign wd        = avs.avs_writedata[WIDTH-1:0];
  assign warm_d    = warm_done ? warm_q : warm_q + 2'd1;

  // A bit's counter only advances while sync sits steady at a value differing from stable.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!warm_done || DEBOUNCE_CYCLES == 0) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else if (sync_q[i] == stable_q[i] || sync_q[i] != sync_prev_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edges are taken on the stable transition itself; warm-up suppresses them entirely.
  assign rise  = stable_d & ~stable_q;
  assign fall  = ~stable_d & stable_q;
  assign edges = warm_done ? ((rise & ~mode_q) | (fall & mode_q)) : '0;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    mode_d = mode_q;
    cap_d  = cap_q;
    if (avs.avs_write) begin
      case (avs.avs_address)
        A_DATA_OUT:  out_d  = wd;
        A_DIR:       dir_d  = wd;
        A_IRQ_MASK:  mask_d = wd;
        A_EDGE_CAP:  cap_d  = cap_q & ~wd;
        A_OUT_SET:   out_d  = out_q | wd;
        A_OUT_CLR:   out_d  = out_q & ~wd;
        A_EDGE_MODE: mode_d = wd;
        default:     ;
      endcase
    end
    cap_d = cap_d | edges;
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        A_DATA_IN:   rdata_d = 32'(stable_q);
        A_DATA_OUT:  rdata_d = 32'(out_q);
        A_DIR:       rdata_d = 32'(dir_q);
        A_IRQ_MASK:  rdata_d = 32'(mask_q);
        A_EDGE_CAP:  rdata_d = 32'(cap_q);
        A_EDGE_MODE: rdata_d = 32'(mode_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      warm_q      <= '0;
      out_q       <= RESET_OUT;
      dir_q       <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      cap_q       <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sync1_q     <= pio_in_port;
      sync_q      <= sync1_q;
      sync_prev_q <= sync_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      out_q       <= out_d;
      dir_q       <= dir_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      cap_q       <= cap_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign pio_out_port     = out_q;
  assign pio_oe           = dir_q;
  assign irq              = irq_q;
  assign avs.avs_readdata = rdata_q;
endmodule

// File: tb/tb_pio_ext.sv
// Self-checking bench for pio_ext: directed scenarios plus randomized bus/pin traffic
// compared every cycle against a window-based behavioural model.
module tb_pio_ext;
  localparam int              W       = 8;
  localparam int              DB      = 4;
  localparam logic [W-1:0]    RST_OUT = 8'hA5;

  logic         clk_clk       = 1'b0;
  logic         reset_reset_n = 1'b0;
  logic [W-1:0] pio_in_port;
  logic [W-1:0] pio_out_port;
  logic [W-1:0] pio_oe;
  logic         irq;

  pio_ext_if bus();

  pio_ext #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .RESET_OUT(RST_OUT)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (bus),
    .pio_in_port   (pio_in_port),
    .pio_out_port  (pio_out_port),
    .pio_oe        (pio_oe),
    .irq           (irq)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs: pins reach the model's sync sample two edges late; a bit's stable value
  // follows sync once the last DB+1 pre-edge sync samples all agree on a new value.
  logic [W-1:0] m_out, m_dir, m_mask, m_mode, m_cap, m_stable, m_p1, m_p2;
  logic         m_irq, m_irq_nx;
  logic [31:0]  m_rd;
  logic [W-1:0] m_win[$];
  int           m_warm;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_wd, m_new, m_edges, m_all1, m_all0;

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_stable);
      3'd1: return 32'(m_out);
      3'd2: return 32'(m_dir);
      3'd3: return 32'(m_mask);
      3'd4: return 32'(m_cap);
      3'd7: return 32'(m_mode);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      m_out = RST_OUT; m_dir = '0; m_mask = '0; m_mode = '0; m_cap = '0;
      m_stable = '0; m_p1 = '0; m_p2 = '0; m_irq = 1'b0; m_rd = '0; m_warm = 0;
      m_win.delete();
      for (int k = 0; k <= DB; k++) m_win.push_back('0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_wd = bus.avs_writedata[W-1:0];
      if (bus.avs_read) m_rd = reg_val(bus.avs_address);
      m_irq_nx = |(m_cap & m_mask);
      m_win.push_back(m_p2);
      void'(m_win.pop_front());
      m_edges = '0;
      if (m_warm < 3) begin
        m_new = m_p2;
      end else begin
        m_all1 = '1; m_all0 = '1;
        foreach (m_win[k]) begin
          m_all1 = m_all1 & m_win[k];
          m_all0 = m_all0 & ~m_win[k];
        end
        m_new   = (m_stable | m_all1) & ~m_all0;
        m_edges = (m_new & ~m_stable & ~m_mode) | (~m_new & m_stable & m_mode);
      end
      if (bus.avs_write) begin
        case (bus.avs_address)
          3'd1: m_out  = m_wd;
          3'd2: m_dir  = m_wd;
          3'd3: m_mask = m_wd;
          3'd4: m_cap  = m_cap & ~m_wd;
          3'd5: m_out  = m_out | m_wd;
          3'd6: m_out  = m_out & ~m_wd;
          3'd7: m_mode = m_wd;
          default: ;
        endcase
      end
      m_cap    = m_cap | m_edges;
      m_stable = m_new;
      m_irq    = m_irq_nx;
      m_p2     = m_p1;
      m_p1     = pio_in_port;
      if (m_warm < 3) m_warm++;
    end
  end

  always @(posedge clk_clk) begin
    #1;
    if (m_valid) begin
      chk("pio_out_port", 32'(pio_out_port), 32'(m_out));
      chk("pio_oe", 32'(pio_oe), 32'(m_dir));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("avs_readdata", bus.avs_readdata, m_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    @(negedge clk_clk);
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1; bus.avs_read = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    bus.avs_address = a; bus.avs_read = 1'b1; bus.avs_write = 1'b0;
    @(negedge clk_clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic setpin(input logic [W-1:0] v);
    @(negedge clk_clk);
    pio_in_port = v; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bit glitch_seen;
    int lat;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    pio_in_port = 8'hF0;

    repeat (3) @(negedge clk_clk);
    chk("reset_out", 32'(pio_out_port), 32'h0000_00A5);
    chk("reset_oe", 32'(pio_oe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset_reset_n = 1'b1;
    repeat (8) idle();
    rd(3'd0, d); chk("data_in_after_warmup", d, 32'h0000_00F0);
    rd(3'd4, d); chk("edge_cap_after_warmup", d, 32'h0);

    // Output register and atomic set/clear
    wr(3'd1, 32'h0F);
    wr(3'd5, 32'hF0);
    chk("out_after_write", 32'(pio_out_port), 32'h0F);
    wr(3'd6, 32'h03);
    chk("out_after_set", 32'(pio_out_port), 32'hFF);
    idle();
    chk("out_after_clr", 32'(pio_out_port), 32'hFC);
    rd(3'd1, d); chk("read_data_out", d, 32'hFC);
    rd(3'd5, d); chk("read_out_set_zero", d, 32'h0);

    // Short glitch on bit0 must be filtered out
    @(negedge clk_clk);
    pio_in_port = 8'hF1; bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    glitch_seen = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk_clk);
      if (j == 3) pio_in_port = 8'hF0;
      if (bus.avs_readdata[0]) glitch_seen = 1'b1;
    end
    chk("glitch_data_in", 32'(glitch_seen), 32'h0);
    rd(3'd4, d); chk("glitch_no_capture", d, 32'h0);

    // Clean rise on bit0: latency from pin change to DATA_IN
    @(negedge clk_clk);
    pio_in_port = 8'hF1; bus.avs_address = 3'd0; bus.avs_read = 1'b1;
    lat = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk_clk);
      if (lat < 0 && bus.avs_readdata[0]) lat = j - 1;
    end
    idle();
    chk("debounce_latency", 32'(lat), 32'd7);

    // Mixed-polarity edge capture and irq
    setpin(8'hF2);
    repeat (10) idle();
    wr(3'd4, 32'hFF);
    wr(3'd7, 32'h2);
    wr(3'd3, 32'h3);
    setpin(8'hF1);
    repeat (10) idle();
    rd(3'd4, d); chk("edge_cap_both", d, 32'h3);
    chk("irq_asserted", 32'(irq), 32'h1);
    wr(3'd4, 32'h1);
    idle();
    rd(3'd4, d); chk("edge_cap_after_w1c0", d, 32'h2);
    chk("irq_still_set", 32'(irq), 32'h1);
    wr(3'd4, 32'h2);
    idle();
    chk("irq_lags_clear", 32'(irq), 32'h1);
    idle();
    chk("irq_cleared", 32'(irq), 32'h0);

    // Edge on bit2 lands on the same edge as its W1C: set wins
    wr(3'd3, 32'h0);
    setpin(8'hF5);
    repeat (5) idle();
    wr(3'd4, 32'h4);
    idle();
    rd(3'd4, d); chk("set_beats_clear", d, 32'h4);
    chk("masked_irq_low", 32'(irq), 32'h0);

    // Reset mid-operation
    wr(3'd2, 32'h3C);
    wr(3'd7, 32'h0);
    setpin(8'h00);
    repeat (10) idle();
    wr(3'd4, 32'hFF);
    setpin(8'hFF);
    repeat (10) idle();
    rd(3'd4, d); chk("capture_all", d, 32'hFF);
    setpin(8'hFE);
    repeat (3) idle();
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk("midreset_out", 32'(pio_out_port), 32'hA5);
    chk("midreset_oe", 32'(pio_oe), 32'h0);
    chk("midreset_irq", 32'(irq), 32'h0);
    chk("midreset_readdata", bus.avs_readdata, 32'h0);
    reset_reset_n = 1'b1;
    repeat (10) idle();
    rd(3'd4, d); chk("no_capture_in_warmup", d, 32'h0);
    rd(3'd0, d); chk("data_in_after_reset", d, 32'h0000_00FE);

    // Randomized traffic, checked each cycle against the model
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_clk);
      if ($urandom_range(0, (n < 1000) ? 3 : 12) == 0)
        pio_in_port = pio_in_port ^ 8'($urandom_range(0, 255));
      bus.avs_read      = 1'($urandom_range(0, 1));
      bus.avs_write     = ($urandom_range(0, 2) == 0);
      bus.avs_address   = 3'($urandom_range(0, 7));
      bus.avs_writedata = $urandom;
    end
    repeat (4) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
